// File: rtl/ifu.sv
// ifu: instruction fetch unit, one outstanding word read per request.
// Ports:
//   clock, reset_n              clock, asynchronous active-low reset
//   reqValid, pc                fetch request from the core (accepted only when idle)
//   flush                       abandon the in-flight fetch
//   memReqValid, memReqReady    memory read request handshake
//   memAddr                     word address of the read (registered pc)
//   memRespValid, memRdata      one-cycle read data pulse from memory
//   respValid, inst, inst_pc    one-cycle result pulse; data held until next result
//   fault                       misaligned pc or memory timeout, qualified by respValid
//   busy                        high whenever a fetch is in progress
module ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          TIMEOUT  = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        reqValid,
   input  logic [31:0] pc,
   input  logic        flush,
   output logic        memReqValid,
   input  logic        memReqReady,
   output logic [31:0] memAddr,
   input  logic        memRespValid,
   input  logic [31:0] memRdata,
   output logic        respValid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        fault,
   output logic        busy
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, RESP} state_t;
   localparam logic [7:0] TO = 8'(TIMEOUT);
   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] pc_q;
   logic        hit;
   assign memAddr = pc_q;
   assign hit     = state_q == WAIT && memRespValid;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (reqValid) state_d = pc[1:0] == 2'b00 ? REQ : RESP;
         REQ:
            if (memReqReady) begin
               state_d = flush ? DROP : WAIT;
               cnt_d   = '0;
            end else if (flush) state_d = IDLE;
         WAIT:
            if (memRespValid) state_d = flush ? IDLE : RESP;
            else begin
               cnt_d   = cnt_q + 8'd1;
               // a flush that coincides with expiry has nothing left to drain
               state_d = cnt_d == TO ? (flush ? IDLE : RESP) : (flush ? DROP : WAIT);
            end
         DROP:
            if (memRespValid) state_d = IDLE;
            else begin
               cnt_d   = cnt_q + 8'd1;
               state_d = cnt_d == TO ? IDLE : DROP;
            end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         pc_q        <= RESET_PC;
         memReqValid <= 1'b0;
         respValid   <= 1'b0;
         busy        <= 1'b0;
         inst        <= '0;
         inst_pc     <= RESET_PC;
         fault       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         memReqValid <= state_d == REQ;
         respValid   <= state_d == RESP;
         busy        <= state_d != IDLE;
         if (state_q == IDLE && reqValid) pc_q <= pc;
         // only a real data beat from WAIT yields an instruction; other RESP entries are faults
         if (state_d == RESP) begin
            inst    <= hit ? memRdata : '0;
            fault   <= !hit;
            inst_pc <= state_q == IDLE ? pc : pc_q;
         end
      end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: randomized and directed checks of ifu against a transaction-level timing model.
module tb_ifu;
   localparam int          TO  = 4;
   localparam logic [31:0] RPC = 32'h8000_0000;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        reqValid = 1'b0;
   logic [31:0] pc = '0;
   logic        flush = 1'b0;
   logic        memReqValid;
   logic        memReqReady = 1'b0;
   logic [31:0] memAddr;
   logic        memRespValid = 1'b0;
   logic [31:0] memRdata = '0;
   logic        respValid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        fault;
   logic        busy;
   int errors = 0;
   int checks = 0;

   ifu #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
      .clock(clock), .reset_n(reset_n), .reqValid(reqValid), .pc(pc), .flush(flush),
      .memReqValid(memReqValid), .memReqReady(memReqReady), .memAddr(memAddr),
      .memRespValid(memRespValid), .memRdata(memRdata), .respValid(respValid),
      .inst(inst), .inst_pc(inst_pc), .fault(fault), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic idle_inputs();
      reqValid = 0; flush = 0; memReqReady = 0; memRespValid = 0; memRdata = $urandom;
   endtask

   task automatic test_reset();
      reset_n = 0;
      repeat (2) @(posedge clock);
      #1;
      checks++; if ({memReqValid, respValid, busy, fault} !== 4'b0) begin errors++; $display("FAIL reset_ctl got=%b exp=0000", {memReqValid, respValid, busy, fault}); end
      checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", inst); end
      checks++; if (inst_pc !== RPC || memAddr !== RPC) begin errors++; $display("FAIL reset_pc got=%h/%h exp=%h", inst_pc, memAddr, RPC); end
      reset_n = 1;
   endtask

   // Model: ready in cycle 1+rdy, data offered in the rsp-th WAIT cycle (0-based).
   // Data is accepted while rsp < TO, else the fetch faults after TO WAIT cycles.
   task automatic run_fetch(input logic [31:0] a, input int rdy, input int rsp, input logic [31:0] d, input bit fl, input bit spam);
      bit mis, acc, exp_f, exp_mrv;
      int exp_c, last, pulses;
      logic [31:0] exp_i;
      mis    = a[1:0] != 2'b00;
      acc    = rsp < TO;
      exp_c  = mis ? 1 : (acc ? 3 + rdy + rsp : 2 + rdy + TO);
      exp_f  = mis || !acc;
      exp_i  = exp_f ? 32'h0 : d;
      last   = (mis ? exp_c : ((2 + rdy + rsp) > exp_c ? 2 + rdy + rsp : exp_c)) + 2;
      pulses = 0;
      reqValid = 1; pc = a; flush = fl;
      for (int c = 1; c <= last; c++) begin
         @(posedge clock); #1;
         reqValid     = spam && c == 1;
         pc           = a + 32'd8;
         flush        = fl && c == exp_c;
         memReqReady  = !mis && c == 1 + rdy;
         memRespValid = !mis && c == 2 + rdy + rsp;
         memRdata     = memRespValid ? d : $urandom;
         exp_mrv      = !mis && c <= 1 + rdy;
         checks++; if (memReqValid !== exp_mrv) begin errors++; $display("FAIL memReqValid c=%0d got=%b exp=%b", c, memReqValid, exp_mrv); end
         if (exp_mrv) begin
            checks++; if (memAddr !== a) begin errors++; $display("FAIL memAddr c=%0d got=%h exp=%h", c, memAddr, a); end
         end
         checks++; if (busy !== (c <= exp_c)) begin errors++; $display("FAIL busy c=%0d got=%b exp=%b", c, busy, c <= exp_c); end
         if (respValid === 1'b1) begin
            pulses++;
            checks++; if (c != exp_c) begin errors++; $display("FAIL resp_cycle got=%0d exp=%0d", c, exp_c); end
            checks++; if (inst !== exp_i || fault !== exp_f || inst_pc !== a) begin errors++; $display("FAIL resp_data got=%h/%b/%h exp=%h/%b/%h", inst, fault, inst_pc, exp_i, exp_f, a); end
         end
      end
      @(posedge clock); #1;
      idle_inputs();
      checks++; if (pulses != 1) begin errors++; $display("FAIL resp_pulses got=%0d exp=1", pulses); end
      checks++; if (inst !== exp_i || fault !== exp_f || inst_pc !== a || busy !== 1'b0) begin errors++; $display("FAIL hold got=%h/%b/%h/%b exp=%h/%b/%h/0", inst, fault, inst_pc, busy, exp_i, exp_f, a); end
   endtask

   // Any flushed fetch must end idle with no result and leave the last result untouched.
   task automatic run_flush(input logic [31:0] a, input int rdy, input int rsp, input int fc);
      logic [31:0] hi, hp;
      logic        hf;
      hi = inst; hp = inst_pc; hf = fault;
      reqValid = 1; pc = a;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clock); #1;
         reqValid     = 0;
         flush        = c == fc;
         memReqReady  = c == 1 + rdy;
         memRespValid = c == 2 + rdy + rsp;
         memRdata     = $urandom;
         checks++; if (respValid !== 1'b0) begin errors++; $display("FAIL flush_resp c=%0d got=%b exp=0", c, respValid); end
         if (fc < 1 + rdy && c == fc + 1) begin
            checks++; if (memReqValid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_req got=%b/%b exp=0/0", memReqValid, busy); end
         end
      end
      @(posedge clock); #1;
      idle_inputs();
      checks++; if (busy !== 1'b0 || inst !== hi || inst_pc !== hp || fault !== hf) begin errors++; $display("FAIL flush_hold got=%b/%h/%h/%b exp=0/%h/%h/%b", busy, inst, inst_pc, fault, hi, hp, hf); end
   endtask

   task automatic test_directed();
      run_fetch(32'h8000_0004, 0, 0, 32'h0010_0093, 0, 0);
      run_fetch(32'h8000_0002, 0, 0, 32'hdead_beef, 0, 0);
      run_fetch(32'h8000_0010, 0, 6, 32'h1234_5678, 0, 0);
      run_fetch(32'h8000_0014, 0, TO - 1, 32'hcafe_f00d, 0, 0);
      run_fetch(32'h8000_0020, 5, 1, 32'h0badc0de, 0, 0);
   endtask

   task automatic test_flush();
      run_flush(32'h8000_0100, 3, 0, 1);
      run_flush(32'h8000_0104, 0, 1, 1);
      run_flush(32'h8000_0108, 0, 30, 1);
      run_flush(32'h8000_010c, 0, 3, 2);
      run_flush(32'h8000_0110, 0, 0, 2);
      run_fetch(32'h8000_0114, 1, 2, 32'h5555_aaaa, 0, 0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      for (int i = 0; i < 20; i++) begin
         a = $urandom;
         if ($urandom_range(3) != 0) a[1:0] = 2'b00;
         run_fetch(a, $urandom_range(4), $urandom_range(7), $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
   endtask

   task automatic test_reset_mid();
      reqValid = 1; pc = 32'h8000_0200;
      @(posedge clock); #1;
      reqValid = 0; memReqReady = 1;
      @(posedge clock); #1;
      memReqReady = 0;
      reset_n = 0;
      #2;
      checks++; if ({memReqValid, respValid, busy, fault} !== 4'b0 || inst !== 32'h0) begin errors++; $display("FAIL mid_reset_ctl got=%b/%h exp=0000/0", {memReqValid, respValid, busy, fault}, inst); end
      checks++; if (inst_pc !== RPC || memAddr !== RPC) begin errors++; $display("FAIL mid_reset_pc got=%h/%h exp=%h", inst_pc, memAddr, RPC); end
      @(posedge clock); #1;
      reset_n = 1; memRespValid = 1; memRdata = 32'h7777_7777;
      for (int c = 0; c < 4; c++) begin
         @(posedge clock); #1;
         memRespValid = 0;
         checks++; if (respValid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_after got=%b/%b exp=0/0", respValid, busy); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      run_fetch(32'h8000_0300, 0, 0, 32'h0000_0013, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, value loaded into pc_q at reset.
REQ-002 Parameter TIMEOUT, default 255, maximum number of WAIT cycles before a fetch fault; range 1..255.
REQ-003 clock  input  1  Single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  Asynchronous, active-low reset.
REQ-005 reqValid  input  1  Fetch request from the core; accepted only in IDLE.
REQ-006 pc  input  32  Fetch address; sampled when reqValid is accepted.
REQ-007 flush  input  1  Abandon the in-flight fetch.
REQ-008 memReqValid  output  1  Memory read request.
REQ-009 memReqReady  input  1  Memory accepts the request.
REQ-010 memAddr  output  32  Word address of the read, equal to pc_q.
REQ-011 memRespValid  input  1  Read data valid, one-cycle pulse.
REQ-012 memRdata  input  32  Read data.
REQ-013 respValid  output  1  One-cycle pulse: inst, inst_pc and fault are valid for the decoder.
REQ-014 inst  output  32  Fetched instruction word.
REQ-015 inst_pc  output  32  Address the instruction was fetched from.
REQ-016 fault  output  1  Qualified by respValid: misaligned PC or timeout.
REQ-017 busy  output  1  High in every state except IDLE.

Function
REQ-018 The block SHALL implement states IDLE, REQ, WAIT, DROP and RESP, one-hot or binary, with all outputs driven from registers.
REQ-019 In IDLE with reqValid=1 and pc[1:0]==0, the block SHALL latch pc into pc_q and go to REQ.
REQ-020 In IDLE with reqValid=1 and pc[1:0]!=0, the block SHALL latch pc, set inst=0 and fault=1, and go to RESP without a memory access.
REQ-021 In REQ, memReqValid SHALL be 1 and memAddr SHALL be stable; on memReqReady=1 the block SHALL go to WAIT and clear the timeout counter.
REQ-022 In WAIT with memRespValid=1, the block SHALL capture memRdata into inst, set fault=0 and go to RESP.
REQ-023 In WAIT, the 8-bit timeout counter SHALL increment each cycle without memRespValid.
REQ-024 When the timeout counter reaches TIMEOUT, the block SHALL set inst=0 and fault=1 and go to RESP.
REQ-025 In RESP, respValid SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-026 Latency: reqValid in cycle 0, memReqValid in cycle 1, memRespValid in cycle k, respValid in cycle k+1.
REQ-027 Minimum latency SHALL be 3 cycles from reqValid to respValid when memReqReady and memRespValid each arrive at the earliest cycle.
REQ-028 reqValid SHALL be ignored in every state except IDLE; a request issued while busy is lost, and the requester SHALL wait for busy=0.
REQ-029 Flush in IDLE or RESP SHALL have no effect; a RESP pulse already scheduled still occurs.
REQ-030 Flush in REQ with memReqReady=0: the block SHALL go to IDLE and drop memReqValid next cycle.
REQ-031 Flush in REQ with memReqReady=1: the block SHALL go to DROP.
REQ-032 Flush in WAIT with memRespValid=0: the block SHALL go to DROP.
REQ-033 Flush in WAIT with memRespValid=1 in the same cycle: the block SHALL discard the data and go to IDLE.
REQ-034 In DROP, the block SHALL wait for memRespValid, discard it, go to IDLE, and never assert respValid.
REQ-035 Timeout SHALL also apply in DROP, returning to IDLE without respValid.
REQ-036 memRespValid arriving in IDLE, REQ or RESP SHALL be ignored.
REQ-037 When timeout and memRespValid coincide in WAIT, the block SHALL accept the data (fault=0).
REQ-038 inst, inst_pc and fault SHALL hold their values after RESP until the next RESP.

Reset
REQ-039 While reset_n=0, the block SHALL be in IDLE with memReqValid=0, respValid=0, busy=0, fault=0, inst=0, the timeout counter at 0, pc_q=RESET_PC and inst_pc=RESET_PC.
REQ-040 Reset asserted mid-fetch SHALL abandon the transaction immediately; any later memRespValid is ignored under REQ-036.

Verification
REQ-041 Normal fetch: pc=0x8000_0004, memReqReady at once, memRdata=0x0010_0093 two cycles later -> one respValid, inst=0x0010_0093, inst_pc=0x8000_0004, fault=0.
REQ-042 Misaligned fetch: pc=0x8000_0002 -> respValid in cycle 1, fault=1, inst=0, memReqValid never asserted.
REQ-043 Timeout: TIMEOUT=4 and no memRespValid -> respValid after exactly 4 WAIT cycles with fault=1; a later memRespValid is ignored.
REQ-044 Flush in WAIT: response arrives 3 cycles after the flush -> no respValid, busy=0 afterwards, and the next fetch returns its own data.
REQ-045 Back-pressure and reset: memReqReady held low for 5 cycles -> memReqValid and memAddr held stable; reset_n pulsed low in WAIT -> IDLE, all outputs at reset values.
